// File: rtl/NXConstants.sv
// -----------------------------------------------------------------------------
// NXConstants
//   Shared Nexus controller types.
//   control_response_t : one beat of a host-bound control response.
// -----------------------------------------------------------------------------
package NXConstants;

    localparam int unsigned CTRL_RESP_WIDTH = 32;

    typedef logic [CTRL_RESP_WIDTH-1:0] control_response_t;

endpackage

// File: rtl/nx_rr_select.sv
// -----------------------------------------------------------------------------
// nx_rr_select
//   Combinational rotate-priority encoder. Returns the first set bit of i_valid
//   at or after i_ptr, wrapping from N-1 back to 0.
//   Ports:
//     i_valid  [N]          request vector
//     i_ptr    [IDX_WIDTH]  highest-priority index for this cycle (< N)
//     o_grant  [N]          one-hot winner, zero when i_valid is zero
//     o_index  [IDX_WIDTH]  index of the winner, zero when nothing is granted
// -----------------------------------------------------------------------------
module nx_rr_select #(
    parameter int unsigned N         = 3,
    parameter int unsigned IDX_WIDTH = $clog2(N)
) (
    input  logic [N-1:0]         i_valid,
    input  logic [IDX_WIDTH-1:0] i_ptr,
    output logic [N-1:0]         o_grant,
    output logic [IDX_WIDTH-1:0] o_index
);

    logic [31:0]          sum;
    logic [IDX_WIDTH-1:0] pos;
    logic                 found;

    always_comb begin
        o_grant = '0;
        o_index = '0;
        found   = 1'b0;
        sum     = '0;
        pos     = '0;
        for (int unsigned off = 0; off < N; off++) begin
            // Wrap once: i_ptr < N and off < N, so sum < 2N.
            sum = 32'(i_ptr) + off;
            if (sum >= N) begin
                sum = sum - N;
            end
            pos = IDX_WIDTH'(sum);
            if (!found && i_valid[pos]) begin
                found        = 1'b1;
                o_grant[pos] = 1'b1;
                o_index      = pos;
            end
        end
    end

endmodule

// File: rtl/nx_ctrl_resp_arbiter.sv
// -----------------------------------------------------------------------------
// nx_ctrl_resp_arbiter
//   Round-robin arbiter for the host-bound control response stream, with
//   burst locking (a beat with last=0 locks the grant to its requester until
//   that requester's last=1 beat) and a single registered output stage.
//   Ports:
//     i_clk, i_rst   clock, synchronous active-high reset
//     i_req_data     per-requester response beat
//     i_req_valid    per-requester valid
//     i_req_last     per-requester end-of-burst marker
//     o_req_ready    per-requester accept (at most one bit set)
//     o_resp_data    registered response to host
//     o_resp_valid   registered valid to host
//     i_resp_ready   host ready
//     o_grant        one-hot requester whose beat is accepted this cycle
//     o_locked       a burst is in progress
// -----------------------------------------------------------------------------
module nx_ctrl_resp_arbiter
    import NXConstants::*;
#(
    parameter int unsigned REQUESTERS = 3,
    parameter int unsigned IDX_WIDTH  = $clog2(REQUESTERS)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  control_response_t     i_req_data [REQUESTERS],
    input  logic [REQUESTERS-1:0] i_req_valid,
    input  logic [REQUESTERS-1:0] i_req_last,
    output logic [REQUESTERS-1:0] o_req_ready,
    output control_response_t     o_resp_data,
    output logic                  o_resp_valid,
    input  logic                  i_resp_ready,
    output logic [REQUESTERS-1:0] o_grant,
    output logic                  o_locked
);

    typedef enum logic {
        ARB_UNLOCKED,
        ARB_LOCKED
    } arb_state_t;

    arb_state_t           state_q, state_d;
    logic [IDX_WIDTH-1:0] ptr_q, ptr_d;
    logic [IDX_WIDTH-1:0] owner_q, owner_d;
    control_response_t    resp_data_q;
    logic                 resp_valid_q;

    logic [REQUESTERS-1:0] eligible;
    logic [REQUESTERS-1:0] sel_grant;
    logic [IDX_WIDTH-1:0]  sel_index;
    logic                  can_accept;
    logic                  accept;
    logic                  accept_last;

    // While locked only the owner may win; if it drops valid the cycle is a
    // bubble rather than a hand-off.
    always_comb begin
        eligible = i_req_valid;
        if (state_q == ARB_LOCKED) begin
            eligible           = '0;
            eligible[owner_q]  = i_req_valid[owner_q];
        end
    end

    nx_rr_select #(
        .N(REQUESTERS)
    ) u_rr_select (
        .i_valid (eligible),
        .i_ptr   (ptr_q),
        .o_grant (sel_grant),
        .o_index (sel_index)
    );

    // Ready is gated by reset so nothing is handed over while requesters are
    // themselves being reset.
    always_comb begin
        can_accept  = !i_rst && (!resp_valid_q || i_resp_ready);
        accept      = can_accept && (|sel_grant);
        accept_last = i_req_last[sel_index];
        o_req_ready = can_accept ? sel_grant : '0;
        o_grant     = o_req_ready;
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            ARB_UNLOCKED: begin
                if (accept && !accept_last) begin
                    state_d = ARB_LOCKED;
                    owner_d = sel_index;
                end
            end
            ARB_LOCKED: begin
                if (accept && accept_last) begin
                    state_d = ARB_UNLOCKED;
                end
            end
            default: state_d = ARB_UNLOCKED;
        endcase
        if (accept && accept_last) begin
            if (sel_index == IDX_WIDTH'(REQUESTERS - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = sel_index + IDX_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ARB_UNLOCKED;
            ptr_q        <= '0;
            owner_q      <= '0;
            resp_data_q  <= '0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            if (accept) begin
                resp_data_q  <= i_req_data[sel_index];
                resp_valid_q <= 1'b1;
            end else if (can_accept) begin
                resp_valid_q <= 1'b0;
            end
        end
    end

    assign o_resp_data  = resp_data_q;
    assign o_resp_valid = resp_valid_q;
    assign o_locked     = (state_q == ARB_LOCKED);

endmodule
